// File: rtl/axi_burst_master_if.sv
// AXI4 bus bundle shared by the burst manager and whatever subordinate sits on the other end.
interface axi_if #(
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   logic [ID_WIDTH-1:0]   arid;
   logic [ADDR_WIDTH-1:0] araddr;
   logic [7:0]            arlen;
   logic [2:0]            arsize;
   logic [1:0]            arburst;
   logic                  arlock;
   logic [3:0]            arcache;
   logic [2:0]            arprot;
   logic [3:0]            arqos;
   logic                  arvalid;
   logic                  arready;

   logic [ID_WIDTH-1:0]   rid;
   logic [DATA_WIDTH-1:0] rdata;
   logic [1:0]            rresp;
   logic                  rlast;
   logic                  rvalid;
   logic                  rready;

   logic [ID_WIDTH-1:0]   awid;
   logic [ADDR_WIDTH-1:0] awaddr;
   logic [7:0]            awlen;
   logic [2:0]            awsize;
   logic [1:0]            awburst;
   logic                  awlock;
   logic [3:0]            awcache;
   logic [2:0]            awprot;
   logic [3:0]            awqos;
   logic                  awvalid;
   logic                  awready;

   logic [DATA_WIDTH-1:0] wdata;
   logic [STRB_WIDTH-1:0] wstrb;
   logic                  wlast;
   logic                  wvalid;
   logic                  wready;

   logic [ID_WIDTH-1:0]   bid;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;

   modport m (
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready,
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready
   );

   modport s (
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready,
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/axi_burst_master.sv
// AXI4 manager turning a command/stream request into one single-ID INCR burst at a time.
// Completion is a one-cycle done pulse with the worst response code seen in the burst.
module axi_burst_master #(
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TXN_ID     = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [7:0]            cmd_len,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic                  rd_last,
   output logic                  done,
   output logic [1:0]            resp_err,
   axi_if.m                      axi_m
);
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned SIZE       = $clog2(STRB_WIDTH);
   localparam logic [ID_WIDTH-1:0] ID = ID_WIDTH'(TXN_ID);

   typedef enum logic [2:0] {IDLE, ADDR_R, DATA_R, ADDR_W, DATA_W, RESP_B} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [7:0]            len_q;
   logic [8:0]            cnt_q;
   logic [1:0]            err_q;

   logic       len_hit, r_hs, r_end, r_early, w_hs, b_done;
   logic [1:0] r_code, b_code, r_merged, b_merged;

   function automatic logic [1:0] max2(input logic [1:0] a, input logic [1:0] b);
      return (a > b) ? a : b;
   endfunction

   // Per-beat response folding: a foreign ID counts as at least SLVERR.
   assign len_hit  = (cnt_q == {1'b0, len_q});
   assign r_hs     = (state == DATA_R) && axi_m.rvalid && rd_ready;
   assign r_end    = r_hs && (axi_m.rlast || len_hit);
   assign r_early  = r_hs && axi_m.rlast && !len_hit;
   assign w_hs     = (state == DATA_W) && wr_valid && axi_m.wready;
   assign b_done   = (state == RESP_B) && axi_m.bvalid;
   assign r_code   = max2(axi_m.rresp, (axi_m.rid != ID) ? 2'b10 : 2'b00);
   assign b_code   = max2(axi_m.bresp, (axi_m.bid != ID) ? 2'b10 : 2'b00);
   assign r_merged = r_early ? 2'b10 : max2(err_q, r_code);
   assign b_merged = max2(err_q, b_code);

   assign done     = r_end || b_done;
   assign resp_err = r_end ? r_merged : (b_done ? b_merged : 2'b00);

   // Controller state, captured command and running beat/error bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cmd_ready <= 1'b0;
         addr_q    <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         err_q     <= '0;
      end else begin
         case (state)
            IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  addr_q    <= cmd_addr;
                  len_q     <= cmd_len;
                  cnt_q     <= '0;
                  err_q     <= '0;
                  state     <= cmd_write ? ADDR_W : ADDR_R;
               end
            end
            ADDR_R: if (axi_m.arready) state <= DATA_R;
            DATA_R: begin
               if (r_hs) begin
                  cnt_q <= cnt_q + 9'd1;
                  err_q <= r_merged;
                  if (r_end) begin
                     state     <= IDLE;
                     cmd_ready <= 1'b1;
                  end
               end
            end
            ADDR_W: if (axi_m.awready) state <= DATA_W;
            DATA_W: begin
               if (w_hs) begin
                  cnt_q <= cnt_q + 9'd1;
                  if (len_hit) state <= RESP_B;
               end
            end
            RESP_B: begin
               if (axi_m.bvalid) begin
                  err_q     <= b_merged;
                  state     <= IDLE;
                  cmd_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read address channel
   assign axi_m.arvalid = (state == ADDR_R);
   assign axi_m.arid    = ID;
   assign axi_m.araddr  = addr_q;
   assign axi_m.arlen   = len_q;
   assign axi_m.arsize  = 3'(SIZE);
   assign axi_m.arburst = 2'b01;
   assign axi_m.arlock  = 1'b0;
   assign axi_m.arcache = 4'd0;
   assign axi_m.arprot  = 3'd0;
   assign axi_m.arqos   = 4'd0;

   // Read data is a zero-latency pass-through while a read burst is active.
   assign axi_m.rready = (state == DATA_R) && rd_ready;
   assign rd_valid     = (state == DATA_R) && axi_m.rvalid;
   assign rd_last      = (state == DATA_R) && axi_m.rlast;
   assign rd_data      = axi_m.rdata;

   // Write address channel
   assign axi_m.awvalid = (state == ADDR_W);
   assign axi_m.awid    = ID;
   assign axi_m.awaddr  = addr_q;
   assign axi_m.awlen   = len_q;
   assign axi_m.awsize  = 3'(SIZE);
   assign axi_m.awburst = 2'b01;
   assign axi_m.awlock  = 1'b0;
   assign axi_m.awcache = 4'd0;
   assign axi_m.awprot  = 3'd0;
   assign axi_m.awqos   = 4'd0;

   // Write data and response channels
   assign axi_m.wvalid = (state == DATA_W) && wr_valid;
   assign wr_ready     = (state == DATA_W) && axi_m.wready;
   assign axi_m.wdata  = wr_data;
   assign axi_m.wstrb  = (state == DATA_W) ? {STRB_WIDTH{1'b1}} : {STRB_WIDTH{1'b0}};
   assign axi_m.wlast  = (state == DATA_W) && len_hit;
   assign axi_m.bready = (state == RESP_B);
endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: the bench plays the AXI subordinate and the requester.
module tb_axi_burst_master;
   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic [31:0] wr_data;
   logic        wr_valid;
   logic        wr_ready;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        rd_ready;
   logic        rd_last;
   logic        done;
   logic [1:0]  resp_err;

   int n_tests = 0;
   int n_fail  = 0;

   axi_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   axi_burst_master #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TXN_ID(0)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
      .done(done), .resp_err(resp_err),
      .axi_m(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a command once cmd_ready is up; returns one step after the handshake edge.
   task automatic issue_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] len);
      int k;
      for (k = 0; k < 10; k++) begin
         if (cmd_ready === 1'b1) break;
         tick();
      end
      chk("cmd_ready_before_cmd", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_len   = len;
      tick();
      cmd_valid = 1'b0;
   endtask

   // Read burst with an always-ready subordinate and requester; RLAST placed on beat last_beat.
   task automatic read_txn(input string tag, input logic [31:0] addr, input logic [7:0] len,
                           input int last_beat, input int err_beat, input logic [1:0] err_code,
                           input logic [3:0] rid_v, input logic [1:0] exp_err);
      issue_cmd(1'b0, addr, len);
      #1;
      chk({tag, "_arvalid"}, 64'(bus.arvalid), 64'd1);
      chk({tag, "_araddr"},  64'(bus.araddr),  64'(addr));
      chk({tag, "_arlen"},   64'(bus.arlen),   64'(len));
      chk({tag, "_arsize"},  64'(bus.arsize),  64'd2);
      chk({tag, "_arburst"}, 64'(bus.arburst), 64'd1);
      chk({tag, "_arid"},    64'(bus.arid),    64'd0);
      bus.arready = 1'b1;
      tick();
      bus.arready = 1'b0;
      rd_ready = 1'b1;
      for (int i = 0; i <= last_beat; i++) begin
         bus.rvalid = 1'b1;
         bus.rdata  = 32'hA0 + 32'(i);
         bus.rlast  = (i == last_beat);
         bus.rresp  = (i == err_beat) ? err_code : 2'b00;
         bus.rid    = rid_v;
         #1;
         chk({tag, "_rd_data"}, 64'(rd_data), 64'(32'hA0 + 32'(i)));
         chk({tag, "_rd_last"}, 64'(rd_last), 64'(i == last_beat));
         chk({tag, "_done"},    64'(done),    64'(i == last_beat));
         if (i == last_beat) chk({tag, "_resp_err"}, 64'(resp_err), 64'(exp_err));
         tick();
      end
      bus.rvalid = 1'b0;
      bus.rlast  = 1'b0;
      bus.rresp  = 2'b00;
      bus.rid    = 4'd0;
      #1;
      chk({tag, "_done_clear"}, 64'(done), 64'd0);
      chk({tag, "_cmd_ready_after"}, 64'(cmd_ready), 64'd1);
   endtask

   // Write burst with an always-ready subordinate; every beat offered immediately.
   task automatic write_txn(input string tag, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] bresp_v, input logic [3:0] bid_v,
                            input logic [1:0] exp_err);
      int wlast_cnt;
      wlast_cnt = 0;
      issue_cmd(1'b1, addr, len);
      #1;
      chk({tag, "_awvalid"}, 64'(bus.awvalid), 64'd1);
      chk({tag, "_awaddr"},  64'(bus.awaddr),  64'(addr));
      chk({tag, "_awlen"},   64'(bus.awlen),   64'(len));
      bus.awready = 1'b1;
      tick();
      bus.awready = 1'b0;
      bus.wready  = 1'b1;
      for (int i = 0; i <= int'(len); i++) begin
         wr_valid = 1'b1;
         wr_data  = 32'(i);
         #1;
         if (bus.wlast === 1'b1) wlast_cnt++;
         chk({tag, "_wlast"}, 64'(bus.wlast), 64'(i == int'(len)));
         chk({tag, "_done_beat"}, 64'(done), 64'd0);
         tick();
      end
      wr_valid   = 1'b0;
      bus.wready = 1'b0;
      #1;
      chk({tag, "_wlast_count"}, 64'(wlast_cnt), 64'd1);
      chk({tag, "_bready"}, 64'(bus.bready), 64'd1);
      bus.bvalid = 1'b1;
      bus.bresp  = bresp_v;
      bus.bid    = bid_v;
      #1;
      chk({tag, "_done"},     64'(done),     64'd1);
      chk({tag, "_resp_err"}, 64'(resp_err), 64'(exp_err));
      tick();
      bus.bvalid = 1'b0;
      bus.bresp  = 2'b00;
      bus.bid    = 4'd0;
      #1;
      chk({tag, "_done_clear"}, 64'(done), 64'd0);
   endtask

   initial begin
      int hs;
      int idx;
      int cyc;
      logic [3:0] pat;

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
      wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0;
      bus.arready = 1'b0; bus.awready = 1'b0; bus.wready = 1'b0;
      bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 1'b0; bus.rid = '0;
      bus.bvalid = 1'b0; bus.bresp = '0; bus.bid = '0;

      // Reset state
      #2;
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("rst_arvalid",   64'(bus.arvalid), 64'd0);
      chk("rst_awvalid",   64'(bus.awvalid), 64'd0);
      chk("rst_wvalid",    64'(bus.wvalid), 64'd0);
      chk("rst_done",      64'(done), 64'd0);
      chk("rst_resp_err",  64'(resp_err), 64'd0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

      // 4-beat read at 0x100, data A0..A3
      read_txn("rd4", 32'h100, 8'd3, 3, -1, 2'b00, 4'd0, 2'b00);

      // Write, 2 beats, AWREADY held off for 3 cycles
      wr_valid = 1'b1;
      wr_data  = 32'h11;
      issue_cmd(1'b1, 32'h200, 8'd1);
      bus.wready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("wrd_awvalid_wait", 64'(bus.awvalid), 64'd1);
         chk("wrd_no_wvalid",    64'(bus.wvalid),  64'd0);
         chk("wrd_no_wr_ready",  64'(wr_ready),    64'd0);
         tick();
      end
      bus.awready = 1'b1;
      #1;
      chk("wrd_no_wvalid_at_aw", 64'(bus.wvalid), 64'd0);
      tick();
      bus.awready = 1'b0;
      #1;
      chk("wrd_awvalid_drop", 64'(bus.awvalid), 64'd0);
      chk("wrd_wvalid0",      64'(bus.wvalid),  64'd1);
      chk("wrd_wdata0",       64'(bus.wdata),   64'h11);
      chk("wrd_wlast0",       64'(bus.wlast),   64'd0);
      chk("wrd_wstrb0",       64'(bus.wstrb),   64'hF);
      tick();
      wr_data = 32'h22;
      #1;
      chk("wrd_wdata1", 64'(bus.wdata), 64'h22);
      chk("wrd_wlast1", 64'(bus.wlast), 64'd1);
      tick();
      wr_valid   = 1'b0;
      bus.wready = 1'b0;
      #1;
      chk("wrd_bready", 64'(bus.bready), 64'd1);
      chk("wrd_wvalid_off", 64'(bus.wvalid), 64'd0);
      bus.bvalid = 1'b1;
      #1;
      chk("wrd_done",     64'(done),     64'd1);
      chk("wrd_resp_err", 64'(resp_err), 64'd0);
      tick();
      bus.bvalid = 1'b0;

      // Read backpressure: rd_ready 1,0,0,1 then held high; subordinate holds each beat
      issue_cmd(1'b0, 32'h300, 8'd3);
      bus.arready = 1'b1;
      tick();
      bus.arready = 1'b0;
      pat = 4'b1001;
      hs  = 0;
      idx = 0;
      cyc = 0;
      while (idx < 4 && cyc < 20) begin
         bus.rvalid = 1'b1;
         bus.rdata  = 32'hB0 + 32'(idx);
         bus.rlast  = (idx == 3);
         rd_ready   = (cyc < 4) ? pat[cyc] : 1'b1;
         #1;
         chk("bp_rready_mirror", 64'(bus.rready), 64'(rd_ready));
         if (bus.rready === 1'b1) begin
            chk("bp_rd_data", 64'(rd_data), 64'(32'hB0 + 32'(idx)));
            chk("bp_done", 64'(done), 64'(idx == 3));
            hs++;
            idx++;
         end
         tick();
         cyc++;
      end
      bus.rvalid = 1'b0;
      bus.rlast  = 1'b0;
      chk("bp_handshakes", 64'(hs), 64'd4);
      chk("bp_cycles", 64'(cyc), 64'd6);

      // Error merging
      read_txn("rderr", 32'h400, 8'd2, 2, 1, 2'b10, 4'd0, 2'b10);
      read_txn("rdearly", 32'h500, 8'd3, 1, -1, 2'b00, 4'd0, 2'b10);
      read_txn("rddec", 32'h540, 8'd1, 1, 0, 2'b11, 4'd0, 2'b11);
      write_txn("wrbid", 32'h600, 8'd0, 2'b00, 4'd1, 2'b10);
      write_txn("wrexok", 32'h640, 8'd0, 2'b01, 4'd0, 2'b01);

      // Reset mid-write after 2 of 4 beats
      issue_cmd(1'b1, 32'h700, 8'd3);
      bus.awready = 1'b1;
      tick();
      bus.awready = 1'b0;
      bus.wready  = 1'b1;
      wr_valid    = 1'b1;
      wr_data     = 32'hC0;
      tick();
      wr_data = 32'hC1;
      tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_wvalid",   64'(bus.wvalid),  64'd0);
      chk("mid_rst_awvalid",  64'(bus.awvalid), 64'd0);
      chk("mid_rst_done",     64'(done),        64'd0);
      chk("mid_rst_wr_ready", 64'(wr_ready),    64'd0);
      tick();
      wr_valid   = 1'b0;
      bus.wready = 1'b0;
      rst_n      = 1'b1;
      tick();
      chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
      read_txn("rd1", 32'h800, 8'd0, 0, -1, 2'b00, 4'd0, 2'b00);

      // 256-beat write
      write_txn("wr256", 32'h1000, 8'd255, 2'b00, 4'd0, 2'b00);
      tick();
      chk("wr256_cmd_ready", 64'(cmd_ready), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
- AXI4 manager (initiator) that turns a simple command/stream request port into single-ID AXI4 INCR bursts.
- Sits between a core-side load/store or DMA engine and the interconnect that leads to the RAM-side AXI subordinates.
- One transaction in flight at a time: read via AR/R, write via AW/W/B.
- Completion is reported with a one-cycle done pulse plus a response code.

Parameters:
- ID_WIDTH, 4: width of AXI ID fields.
- ADDR_WIDTH, 32: byte address width.
- DATA_WIDTH, 32: AXI data width; must be a power of 2 and at least 8.
- TXN_ID, 0: constant value driven on ARID and AWID.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_WIDTH  start byte address; the requester aligns it to DATA_WIDTH/8.
- cmd_len  in  8  beats minus 1 (AXI LEN encoding).
- wr_data  in  DATA_WIDTH  write beat data.
- wr_valid  in  1  write beat valid.
- wr_ready  out  1  write beat accepted.
- rd_data  out  DATA_WIDTH  read beat data.
- rd_valid  out  1  read beat valid.
- rd_ready  in  1  read beat accepted.
- rd_last  out  1  marks the final read beat.
- done  out  1  one-cycle pulse at transaction end.
- resp_err  out  2  sticky-merged response code, valid while done is high.
- axi_m  interface  axi_if.m  AXI4 manager port.

Behaviour:
- Reset:
  - Asynchronous, active-low. Assertion at any time, including mid-burst, forces state IDLE immediately.
  - All valid and ready outputs, done and resp_err go to 0.
  - Beat counter and error register clear. No done pulse is produced for an aborted transaction.
- States: IDLE, ADDR_R, DATA_R, ADDR_W, DATA_W, RESP_B.
- IDLE:
  - cmd_ready = 1; all other handshake outputs = 0.
  - On a cmd handshake, register addr, len and write, clear the beat counter and error register.
  - Next state is ADDR_W if write, otherwise ADDR_R. No combinational path from cmd_valid to any AXI signal.
- ADDR_R:
  - ARVALID = 1 with registered values: ARADDR, ARLEN = len, ARID = TXN_ID, ARSIZE = log2(DATA_WIDTH/8), ARBURST = 2'b01.
  - All ARx fields are held stable until ARREADY.
  - On ARREADY go to DATA_R. ARVALID must never drop before the handshake.
- DATA_R:
  - rd_data = RDATA, rd_valid = RVALID, RREADY = rd_ready (pass-through, zero latency), rd_last = RLAST.
  - On each R handshake: count the beat; set error bits per the merge rule below.
  - On a handshake with RLAST = 1, or with beat count == len, go to IDLE and pulse done.
  - RLAST arriving early (count < len) ends the burst with resp_err forced to 2'b10.
- ADDR_W:
  - AWVALID = 1 with AW fields encoded the same way as AR.
  - On AWREADY go to DATA_W. No W beat is offered before the AW handshake.
- DATA_W:
  - WVALID = wr_valid, wr_ready = WREADY, WDATA = wr_data, WSTRB = all ones.
  - WLAST = 1 exactly when beat count == len.
  - Count on each W handshake; after the handshake carrying WLAST, go to RESP_B.
- RESP_B:
  - BREADY = 1. On BVALID, merge BRESP per the rule below, pulse done, return to IDLE.
- Error merge:
  - resp_err = max of all RRESP/BRESP codes seen in the transaction (OKAY 00 < EXOKAY 01 < SLVERR 10 < DECERR 11).
  - RID/BID not equal to TXN_ID raises resp_err to at least 2'b10.
- Fixed AXI outputs:
  - ARLOCK, AWLOCK, ARCACHE, AWCACHE, ARPROT, AWPROT, ARQOS and AWQOS are driven 0.
  - Signals not listed for a state are driven 0, except that address and data fields hold their registered values.
- Counting and address:
  - Beat counter is 9 bits wide, so cmd_len = 255 (256 beats) does not wrap.
  - The 4 KB boundary rule is the requester's responsibility; no splitting is done here.
- Throughput:
  - Back-to-back commands: cmd_ready rises the cycle after done. Minimum one IDLE cycle between transactions.
  - Single-beat read with zero-wait subordinate: cmd handshake at cycle 0, ARVALID at 1, R beat at 2, done at 2.

Test Plan:
- Read, cmd_addr = 0x100, cmd_len = 3, subordinate returns 0xA0..0xA3 with RLAST on beat 3:
  - ARADDR = 0x100, ARLEN = 3, ARSIZE = 2, ARBURST = 01.
  - rd_data sequence A0..A3, rd_last on 4th beat, done with resp_err = 00.
- Write, cmd_len = 1, data 0x11 then 0x22, AWREADY delayed 3 cycles:
  - No WVALID before the AW handshake; WLAST only on 0x22.
  - BRESP = 00, so done with resp_err = 00.
- Backpressure: rd_ready toggles 1,0,0,1 during a 4-beat read:
  - RREADY mirrors rd_ready; no beat is lost or duplicated; exactly 4 handshakes.
- Errors: RRESP = 10 on beat 1 of 3 → done with resp_err = 10. BID = TXN_ID+1 on a write → resp_err = 10.
- rst_n asserted while in DATA_W after beat 2 of 4:
  - WVALID, AWVALID and done = 0 immediately; cmd_ready = 1 after release.
  - A fresh read then completes normally.
- cmd_len = 255 write: exactly 256 W handshakes, WLAST on the 256th, single done pulse.
